// File: rtl/hsk_stim_pkg.sv
// Shared types and defaults for the handshake stimulus generator.
// Optional fault injection in the top is enabled by defining HSK_FAULT_INJECT_EN.
package hsk_stim_pkg;

    localparam int DEF_LEN_W = 8;
    localparam int DEF_CNT_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_GAP   = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_FIN   = 3'd4;

    function automatic logic is_busy_state(input state_t s);
        return (s == ST_REQ) || (s == ST_GAP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/hsk_ack_data_drv.sv
// Registered ack/data stage: ack follows req by one cycle (unless masked),
// data toggles in the cycle after every ack-high cycle.
module hsk_ack_data_drv (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic ack_mask_i,
    output logic ack_o,
    output logic data_o
);

    logic ack_d;
    logic ack_q;
    logic data_d;
    logic data_q;

    // Next-state for ack and data; data follows the ack actually driven.
    always_comb begin
        ack_d  = req_i & ~ack_mask_i;
        data_d = data_q ^ ack_q;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            data_q <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            data_q <= data_d;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = data_q;

endmodule

// File: rtl/hsk_stim_gen.sv
// Burst stimulus generator for the req/ack/data handshake checker.
// Define HSK_FAULT_INJECT_EN to add fault_en/fault_idx and a one-shot ack dropout.
module hsk_stim_gen
    import hsk_stim_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [LEN_W-1:0] gap_len,
    input  logic [CNT_W-1:0] num_bursts,
`ifdef HSK_FAULT_INJECT_EN
    input  logic             fault_en,
    input  logic [CNT_W-1:0] fault_idx,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bursts_done,
    output logic             req,
    output logic             ack,
    output logic             data
);

    state_t           state_d, state_q;
    logic [LEN_W-1:0] cnt_d, cnt_q;
    logic [LEN_W-1:0] blen_d, blen_q;
    logic [LEN_W-1:0] glen_d, glen_q;
    logic [CNT_W-1:0] nbur_d, nbur_q;
    logic [CNT_W-1:0] bdone_d, bdone_q;
    logic             req_d, req_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             last_burst_s;
    logic             fault_mask_s;

    assign last_burst_s = ((bdone_q + CNT_W'(1)) >= nbur_q);

    // Sequencer: burst/gap/drain timing and completed-burst count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blen_d  = blen_q;
        glen_d  = glen_q;
        nbur_d  = nbur_q;
        bdone_d = bdone_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((burst_len != '0) && (num_bursts != '0)) begin
                        blen_d  = burst_len;
                        glen_d  = gap_len;
                        nbur_d  = num_bursts;
                        bdone_d = '0;
                        cnt_d   = burst_len - LEN_W'(1);
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cnt_q == '0) begin
                    if (bdone_q != nbur_q) begin
                        bdone_d = bdone_q + CNT_W'(1);
                    end else begin
                        bdone_d = bdone_q;
                    end
                    if (last_burst_s) begin
                        cnt_d   = LEN_W'(1);
                        state_d = ST_DRAIN;
                    end else if (glen_q != '0) begin
                        cnt_d   = glen_q - LEN_W'(1);
                        state_d = ST_GAP;
                    end else begin
                        cnt_d   = blen_q - LEN_W'(1);
                        state_d = ST_REQ;
                    end
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    cnt_d   = blen_q - LEN_W'(1);
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from the next state so they align with it.
        req_d  = (state_d == ST_REQ);
        busy_d = is_busy_state(state_d);
        done_d = (state_d == ST_FIN);
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            blen_q  <= '0;
            glen_q  <= '0;
            nbur_q  <= '0;
            bdone_q <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blen_q  <= blen_d;
            glen_q  <= glen_d;
            nbur_q  <= nbur_d;
            bdone_q <= bdone_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef HSK_FAULT_INJECT_EN
    logic             fen_d, fen_q;
    logic [CNT_W-1:0] fidx_d, fidx_q;

    // Fault configuration is captured only with an accepted start.
    always_comb begin
        fen_d  = fen_q;
        fidx_d = fidx_q;
        if ((state_q == ST_IDLE) && start) begin
            fen_d  = fault_en;
            fidx_d = fault_idx;
        end else begin
            fen_d  = fen_q;
            fidx_d = fidx_q;
        end
    end

    // Fault configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fen_q  <= 1'b0;
            fidx_q <= '0;
        end else begin
            fen_q  <= fen_d;
            fidx_q <= fidx_d;
        end
    end

    // The first req cycle of a burst is the one where the counter was just loaded.
    assign fault_mask_s = fen_q && (state_q == ST_REQ) &&
                          (cnt_q == (blen_q - LEN_W'(1))) && (bdone_q == fidx_q);
`else
    assign fault_mask_s = 1'b0;
`endif

    hsk_ack_data_drv u_drv (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_q),
        .ack_mask_i (fault_mask_s),
        .ack_o      (ack),
        .data_o     (data)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign bursts_done = bdone_q;
    assign req         = req_q;

endmodule

// File: tb/tb_hsk_stim_gen.sv
// Scoreboard bench for hsk_stim_gen: per-sequence expectations are queued at start
// and checked against monitored req/ack/data activity when done pulses.
module tb_hsk_stim_gen;

    localparam int LEN_W = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic [LEN_W-1:0] gap_len;
    logic [CNT_W-1:0] num_bursts;
`ifdef HSK_FAULT_INJECT_EN
    logic             fault_en;
    logic [CNT_W-1:0] fault_idx;
    localparam int EXP_ACK_VIOL = 1;
`else
    localparam int EXP_ACK_VIOL = 0;
`endif
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bursts_done;
    logic             req;
    logic             ack;
    logic             data;

    typedef struct {
        int bd;
        int nreq;
        int nack;
        int ntog;
        int nrise;
        int ncyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ack_viol = 0;
    int   data_viol = 0;
    int   c_req, c_ack, c_tog, c_rise, c_cyc;
    logic p_req, p_ack, p_data;

    hsk_stim_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .burst_len   (burst_len),
        .gap_len     (gap_len),
        .num_bursts  (num_bursts),
`ifdef HSK_FAULT_INJECT_EN
        .fault_en    (fault_en),
        .fault_idx   (fault_idx),
`endif
        .busy        (busy),
        .done        (done),
        .bursts_done (bursts_done),
        .req         (req),
        .ack         (ack),
        .data        (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: accumulate activity, check handshake rules, pop expectation on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            c_req = 0; c_ack = 0; c_tog = 0; c_rise = 0; c_cyc = 0;
            p_req = 1'b0; p_ack = 1'b0; p_data = 1'b0;
        end else begin
            if (ack !== p_req) ack_viol++;
            if (data !== (p_data ^ p_ack)) data_viol++;
            if (req && !p_req) c_rise++;
            c_req += int'(req);
            c_ack += int'(ack);
            if (data !== p_data) c_tog++;
            c_cyc++;
            if (start && !busy && !done) begin
                c_req = 0; c_ack = 0; c_tog = 0; c_rise = 0; c_cyc = 0;
            end
            if (done) begin
                check("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("bursts_done", 32'(bursts_done), 32'(e.bd));
                    check("req_cycles",  32'(c_req),  32'(e.nreq));
                    check("ack_cycles",  32'(c_ack),  32'(e.nack));
                    check("data_toggles", 32'(c_tog), 32'(e.ntog));
                    check("req_rises",   32'(c_rise), 32'(e.nrise));
                    check("start_to_done", 32'(c_cyc), 32'(e.ncyc));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
            p_req = req; p_ack = ack; p_data = data;
        end
    end

    task automatic fire(input int bl, input int gl, input int nb);
        burst_len  = LEN_W'(bl);
        gap_len    = LEN_W'(gl);
        num_bursts = CNT_W'(nb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_seq(input int bl, input int gl, input int nb,
                           input int e_req, input int e_ack, input int e_tog,
                           input int e_rise, input int e_cyc, input int e_bd,
                           input bit poke);
        exp_t e;
        e.bd = e_bd; e.nreq = e_req; e.nack = e_ack;
        e.ntog = e_tog; e.nrise = e_rise; e.ncyc = e_cyc;
        sb.push_back(e);
        fire(bl, gl, nb);
        if (poke) begin
            repeat (3) begin @(posedge clk); #1; end
            fire(5, 0, 1);
        end
        wait_drain();
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0;
        burst_len = '0; gap_len = '0; num_bursts = '0;
`ifdef HSK_FAULT_INJECT_EN
        fault_en = 1'b0; fault_idx = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bursts_done", 32'(bursts_done), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero configurations: straight to FIN, no req activity.
        run_seq(3, 0, 0, 0, 0, 0, 0, 1, 0, 1'b0);
        run_seq(0, 2, 2, 0, 0, 0, 0, 1, 0, 1'b0);
        // Single burst of 3.
        run_seq(3, 0, 1, 3, 3, 3, 1, 6, 1, 1'b0);
        // Three bursts of 2 with gap 4, plus an ignored start while busy.
        run_seq(2, 4, 3, 6, 6, 6, 3, 17, 3, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        check("bursts_done_hold", 32'(bursts_done), 32'd3);
        // Back-to-back single-cycle bursts.
        run_seq(1, 0, 4, 4, 4, 4, 1, 7, 4, 1'b0);

        // Reset during burst 2 of 3; no completion may be reported.
        fire(2, 1, 3);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (bursts_done == CNT_W'(1) && req) found = 1'b1;
        end
        check("reached_burst2", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bursts_done", 32'(bursts_done), 32'd0);
        check("midrst_req", 32'(req), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_data", 32'(data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_seq(2, 1, 3, 6, 6, 6, 3, 11, 3, 1'b0);

`ifdef HSK_FAULT_INJECT_EN
        // Burst 1 loses ack after its first req cycle.
        fault_en = 1'b1; fault_idx = CNT_W'(1);
        run_seq(2, 0, 2, 4, 3, 3, 1, 7, 2, 1'b0);
        // Out-of-range index has no effect.
        fault_idx = CNT_W'(5);
        run_seq(2, 0, 2, 4, 4, 4, 1, 7, 2, 1'b0);
        fault_en = 1'b0;
`else
        run_seq(2, 0, 2, 4, 4, 4, 1, 7, 2, 1'b0);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("ack_violations", 32'(ack_viol), 32'(EXP_ACK_VIOL));
        check("data_violations", 32'(data_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
